// File: rtl/sram_bitstream_reader_if.sv
// Bundles the SRAM read port and the bit-stream consumer port of the bitstream reader.
interface sram_bitstream_reader_if;
    logic        start;
    logic [17:0] sram_address;
    logic        sram_we_n;
    logic [15:0] sram_read_data;
    logic [15:0] bits_out;
    logic        bits_valid;
    logic        consume;
    logic [4:0]  consume_len;
    logic [5:0]  bits_count;
    logic        busy;
    logic        exhausted;

    modport slave (
        input  start, sram_read_data, consume, consume_len,
        output sram_address, sram_we_n, bits_out, bits_valid, bits_count, busy, exhausted
    );

    modport master (
        output start, sram_read_data, consume, consume_len,
        input  sram_address, sram_we_n, bits_out, bits_valid, bits_count, busy, exhausted
    );
endinterface

// File: rtl/sram_bitstream_reader.sv
// Streams SRAM words START_ADDR..END_ADDR through a small prefetch FIFO into a
// 32-bit left-aligned bit buffer from which the consumer pulls 1..16 bits per cycle.
module sram_bitstream_reader #(
    parameter logic [17:0] START_ADDR = 18'h6C00,
    parameter logic [17:0] END_ADDR   = 18'h3FFFF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_bitstream_reader_if.slave  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t        state;
    logic [18:0]   next_addr;       // one extra bit so the counter can pass 3FFFF without wrapping
    logic [17:0]   last_addr;
    logic [1:0]    inflight;
    logic [15:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [31:0]   bit_buf;
    logic [5:0]    bit_cnt;
    logic          busy_r, exhausted_r;

    logic          addr_ok, issue, fifo_wr, refill, exhaust;
    logic [5:0]    len_eff, rem, cnt_next;
    logic [31:0]   buf_next;
    int            occ;

    always_comb begin
        occ      = int'(fifo_cnt) + int'(inflight[0]) + int'(inflight[1]);
        addr_ok  = (next_addr <= {1'b0, END_ADDR});
        issue    = (state == FETCH) && !bus.start && (occ < FIFO_DEPTH) && addr_ok;
        fifo_wr  = inflight[1];

        len_eff = 6'd0;
        if (bus.consume && (bit_cnt >= 6'd16) && (bus.consume_len != 5'd0))
            len_eff = (bus.consume_len > 5'd16) ? 6'd16 : {1'b0, bus.consume_len};

        rem      = bit_cnt - len_eff;
        refill   = (rem <= 6'd16) && (fifo_cnt != '0);
        // The popped word lands directly below the surviving bits.
        buf_next = (bit_buf << len_eff) | (refill ? ({fifo_mem[rd_ptr], 16'h0000} >> rem) : 32'h0);
        cnt_next = refill ? (rem + 6'd16) : rem;

        exhaust  = !addr_ok && (inflight == 2'b00) && (fifo_cnt == '0) && (bit_cnt < 6'd16);
    end

    assign bus.sram_address = issue ? next_addr[17:0] : last_addr;
    assign bus.sram_we_n    = 1'b1;
    assign bus.bits_out     = bit_buf[31:16];
    assign bus.bits_valid   = (bit_cnt >= 6'd16);
    assign bus.bits_count   = bit_cnt;
    assign bus.busy         = busy_r;
    assign bus.exhausted    = exhausted_r;

    always_ff @(posedge clk) begin
        if (fifo_wr && !bus.start)
            fifo_mem[wr_ptr] <= bus.sram_read_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            next_addr   <= '0;
            last_addr   <= '0;
            inflight    <= 2'b00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            bit_buf     <= '0;
            bit_cnt     <= '0;
            busy_r      <= 1'b0;
            exhausted_r <= 1'b0;
        end else if (bus.start) begin
            state       <= FETCH;
            next_addr   <= {1'b0, START_ADDR};
            inflight    <= 2'b00;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_cnt    <= '0;
            bit_buf     <= '0;
            bit_cnt     <= '0;
            busy_r      <= 1'b1;
            exhausted_r <= 1'b0;
        end else begin
            inflight <= {inflight[0], issue};
            if (issue) begin
                next_addr <= next_addr + 19'd1;
                last_addr <= next_addr[17:0];
            end
            if (fifo_wr)
                wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (refill)
                rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({fifo_wr, refill})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            bit_buf <= buf_next;
            bit_cnt <= cnt_next;
            if (state == FETCH && exhaust) begin
                state       <= DONE;
                busy_r      <= 1'b0;
                exhausted_r <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_bitstream_reader.sv
// Directed bench: cold start, mixed consume, backpressure, restart, reset, end boundary.
module tb_sram_bitstream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_bitstream_reader_if ia ();
    sram_bitstream_reader_if ib ();

    sram_bitstream_reader dut_a (.clk(clk), .rst(rst), .bus(ia));
    sram_bitstream_reader #(.END_ADDR(18'h6C03)) dut_b (.clk(clk), .rst(rst), .bus(ib));

    // SRAM models: word[a] = a[15:0], valid two cycles after the address
    logic [17:0] a_d1, a_d2, b_d1, b_d2;
    always @(posedge clk) begin
        a_d1 <= ia.sram_address; a_d2 <= a_d1;
        b_d1 <= ib.sram_address; b_d2 <= b_d1;
    end
    assign ia.sram_read_data = a_d2[15:0];
    assign ib.sram_read_data = b_d2[15:0];

    int          b_changes = 0;
    logic [17:0] b_prev    = '0;
    always @(posedge clk) begin
        if (ib.sram_address != b_prev) b_changes++;
        b_prev = ib.sram_address;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_bits(input int p, input int len);
        logic [15:0] r = '0;
        logic [15:0] w;
        for (int i = 0; i < len; i++) begin
            w = 16'(32'h6C00 + (p + i) / 16);
            r = {r[14:0], w[15 - ((p + i) % 16)]};
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid_a(input string tag);
        int g = 0;
        while (!ia.bits_valid && g < 20) begin
            ia.consume = 1'b0;
            tick();
            g++;
        end
        check_val(tag, ia.bits_valid, 1);
    endtask

    task automatic wait_valid_b(input string tag);
        int g = 0;
        while (!ib.bits_valid && g < 20) begin
            ib.consume = 1'b0;
            tick();
            g++;
        end
        check_val(tag, ib.bits_valid, 1);
    endtask

    task automatic check_reset_a(input string tag);
        check_val({tag, "_addr"},  ia.sram_address, 0);
        check_val({tag, "_we_n"},  ia.sram_we_n, 1);
        check_val({tag, "_bits"},  ia.bits_out, 0);
        check_val({tag, "_cnt"},   ia.bits_count, 0);
        check_val({tag, "_valid"}, ia.bits_valid, 0);
        check_val({tag, "_busy"},  ia.busy, 0);
        check_val({tag, "_exh"},   ia.exhausted, 0);
    endtask

    task automatic cold_start_a(input string tag);
        ia.start = 1'b1;
        tick();
        ia.start = 1'b0;
        #1;
        check_val({tag, "_addr_c1"}, ia.sram_address, 18'h6C00);
        check_val({tag, "_busy"}, ia.busy, 1);
        tick(); tick(); tick();
        check_val({tag, "_valid_c4"}, ia.bits_valid, 0);
        tick();
        check_val({tag, "_valid_c5"}, ia.bits_valid, 1);
        check_val({tag, "_bits_c5"}, ia.bits_out, 16'h6C00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int lens[4] = '{3, 13, 16, 1};
        logic [17:0] addr_hold;
        ia.start = 0; ia.consume = 0; ia.consume_len = 0;
        ib.start = 0; ib.consume = 0; ib.consume_len = 0;
        tick(); tick();
        check_reset_a("rst");
        check_val("rst_b_addr", ib.sram_address, 0);
        check_val("rst_b_exh", ib.exhausted, 0);
        rst = 1'b0;
        tick();

        // cold start and sustained 16 bits per cycle
        cold_start_a("cold");
        p = 0;
        for (int k = 0; k < 12; k++) begin
            check_val("sust_valid", ia.bits_valid, 1);
            check_val("sust_bits", ia.bits_out, exp_bits(p, 16));
            ia.consume = 1'b1; ia.consume_len = 5'd16; p += 16;
            tick();
        end

        // mixed consume lengths
        for (int k = 0; k < 48; k++) begin
            int len = lens[k % 4];
            wait_valid_a("mix_valid");
            check_val("mix_bits", 32'(ia.bits_out >> (16 - len)), exp_bits(p, len));
            check_val("mix_cnt_le32", ia.bits_count <= 6'd32, 1);
            ia.consume = 1'b1; ia.consume_len = 5'(len); p += len;
            tick();
        end
        if (p % 16 != 0) begin
            int len = 16 - p % 16;
            wait_valid_a("align_valid");
            check_val("align_bits", 32'(ia.bits_out >> (16 - len)), exp_bits(p, len));
            ia.consume = 1'b1; ia.consume_len = 5'(len); p += len;
            tick();
        end

        // Consume_len = 0 removes nothing
        wait_valid_a("len0_valid");
        ia.consume = 1'b1; ia.consume_len = 5'd0;
        tick();
        check_val("len0_bits", ia.bits_out, exp_bits(p, 16));

        // backpressure
        ia.consume = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        addr_hold = ia.sram_address;
        for (int k = 0; k < 10; k++) tick();
        check_val("bp_addr_hold", ia.sram_address, addr_hold);
        check_val("bp_addr", ia.sram_address, 18'(32'h6C00 + p / 16 + 5));
        check_val("bp_cnt", ia.bits_count, 32);
        check_val("bp_bits", ia.bits_out, exp_bits(p, 16));
        for (int k = 0; k < 20; k++) begin
            wait_valid_a("resume_valid");
            check_val("resume_bits", ia.bits_out, exp_bits(p, 16));
            ia.consume = 1'b1; ia.consume_len = 5'd16; p += 16;
            tick();
        end

        // restart while reads are in flight
        ia.consume = 1'b0;
        cold_start_a("restart");
        p = 0;
        for (int k = 0; k < 6; k++) begin
            wait_valid_a("restart_valid");
            check_val("restart_bits", ia.bits_out, exp_bits(p, 16));
            ia.consume = 1'b1; ia.consume_len = 5'd16; p += 16;
            tick();
        end

        // reset mid-stream
        rst = 1'b1; ia.consume = 1'b0;
        #1;
        check_reset_a("midrst");
        tick();
        rst = 1'b0;
        tick(); tick(); tick();
        check_val("postrst_cnt", ia.bits_count, 0);
        check_val("postrst_busy", ia.busy, 0);
        cold_start_a("rst_cold");

        // end boundary on the short instance
        b_changes = 0;
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid_b("end_valid");
            check_val("end_bits", ib.bits_out, 16'(16'h6C00 + k));
            check_val("end_exh_early", ib.exhausted, 0);
            ib.consume = 1'b1; ib.consume_len = 5'd16;
            tick();
        end
        ib.consume = 1'b0;
        tick(); tick();
        check_val("end_exh", ib.exhausted, 1);
        check_val("end_busy", ib.busy, 0);
        check_val("end_cnt", ib.bits_count, 0);
        check_val("end_reads", b_changes, 4);
        check_val("end_addr", ib.sram_address, 18'h6C03);

        // residual bits stay readable in DONE
        ib.start = 1'b1;
        tick();
        ib.start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_valid_b("resid_valid");
            check_val("resid_bits", ib.bits_out, 16'(16'h6C00 + k));
            ib.consume = 1'b1; ib.consume_len = 5'd16;
            tick();
        end
        wait_valid_b("resid_valid8");
        ib.consume = 1'b1; ib.consume_len = 5'd8;
        tick();
        ib.consume = 1'b0;
        tick(); tick();
        check_val("resid_cnt", ib.bits_count, 8);
        check_val("resid_exh", ib.exhausted, 1);
        check_val("resid_bits_out", ib.bits_out, 16'h0300);
        check_val("resid_valid0", ib.bits_valid, 0);
        ib.consume = 1'b1; ib.consume_len = 5'd8;
        tick(); tick();
        check_val("ignored_consume_cnt", ib.bits_count, 8);
        ib.consume = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
